// File: rtl/gpredict_ctrl.sv
// ---------------------------------------------------------------------------
// gpredict_ctrl
// Speculation controller for a gshare global branch predictor.
// Owns the speculative global history register (ghr), forms the PHT read
// index, keeps up to DEPTH in-flight predictions in an in-order queue,
// retires resolutions in order, writes back the updated 2-bit saturating
// counter, repairs the ghr on a mispredict and counts mispredicts.
//
// Optional feature macro: GPREDICT_CTRL_STATS_EN
//   defined   : resolved_count counts every retired branch (saturating)
//   undefined : resolved_count is tied to zero, no counter register exists
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   pred_valid/ready   predict request handshake (ready = queue not full)
//   pred_pc            branch PC of the predict request
//   pred_taken         prediction, combinational from pht_rd_ctr
//   pht_rd_idx/ctr     combinational PHT read port
//   res_valid/taken    in-order resolution of the oldest in-flight branch
//   pht_wr_en/idx/ctr  registered PHT write port
//   flush              1-cycle pulse after a mispredict
//   res_err            1-cycle pulse after a resolution with an empty queue
//   ghr                speculative global history
//   inflight           queue occupancy
//   mispredict_count   saturating mispredict count since reset
//   resolved_count     saturating retired-branch count (see macro above)
// ---------------------------------------------------------------------------
module gpredict_ctrl #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned GHR_W = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pred_valid,
   output logic                    pred_ready,
   input  logic [PC_W-1:0]         pred_pc,
   output logic                    pred_taken,
   output logic [GHR_W-1:0]        pht_rd_idx,
   input  logic [1:0]              pht_rd_ctr,
   input  logic                    res_valid,
   input  logic                    res_taken,
   output logic                    pht_wr_en,
   output logic [GHR_W-1:0]        pht_wr_idx,
   output logic [1:0]              pht_wr_ctr,
   output logic                    flush,
   output logic                    res_err,
   output logic [GHR_W-1:0]        ghr,
   output logic [$clog2(DEPTH):0]  inflight,
   output logic [31:0]             mispredict_count,
   output logic [31:0]             resolved_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned MIN_W = (PC_W < GHR_W) ? PC_W : GHR_W;

   // In-flight queue storage: one entry per predicted, unresolved branch
   logic [GHR_W-1:0] q_idx  [DEPTH];
   logic [1:0]       q_ctr  [DEPTH];
   logic             q_pred [DEPTH];
   logic [GHR_W-1:0] q_ghr  [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic [GHR_W-1:0] pc_ext;
   logic             accept;
   logic             pop;
   logic             push;
   logic             mispredict;
   logic [GHR_W-1:0] head_idx;
   logic [1:0]       head_ctr;
   logic             head_pred;
   logic [GHR_W-1:0] head_ghr;
   logic [1:0]       new_ctr;

   // Index and prediction are pure combinational functions of the request
   assign pc_ext      = GHR_W'(pred_pc[MIN_W-1:0]);
   assign pht_rd_idx  = pc_ext ^ ghr;
   assign pred_taken  = pht_rd_ctr[1];

   // Ready depends on registered occupancy only, so a pop never frees a slot
   // for a same-cycle accept
   assign pred_ready  = (count != CNT_W'(DEPTH));
   assign accept      = pred_valid && pred_ready;
   assign pop         = res_valid && (count != '0);

   assign head_idx    = q_idx[rd_ptr];
   assign head_ctr    = q_ctr[rd_ptr];
   assign head_pred   = q_pred[rd_ptr];
   assign head_ghr    = q_ghr[rd_ptr];

   assign mispredict  = pop && (res_taken != head_pred);
   // A mispredict flushes the queue, so a same-cycle accept is dropped
   assign push        = accept && !mispredict;
   assign inflight    = count;

   // Saturating 2-bit counter update from the predict-time snapshot
   always_comb begin
      new_ctr = head_ctr;
      if (res_taken) begin
         if (head_ctr != 2'd3) new_ctr = head_ctr + 2'd1;
      end else begin
         if (head_ctr != 2'd0) new_ctr = head_ctr - 2'd1;
      end
   end

   // Queue payload: written on push, no reset needed (pointers gate validity)
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         q_idx[wr_ptr]  <= pht_rd_idx;
         q_ctr[wr_ptr]  <= pht_rd_ctr;
         q_pred[wr_ptr] <= pred_taken;
         q_ghr[wr_ptr]  <= ghr;
      end
   end

   // Pointers, occupancy and speculative history
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ghr    <= '0;
      end else if (mispredict) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         // Repair: history as it was before the bad branch, plus its real outcome
         ghr    <= {head_ghr[GHR_W-2:0], res_taken};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            ghr    <= {ghr[GHR_W-2:0], pred_taken};
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   // Registered PHT write port and status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         pht_wr_en  <= 1'b0;
         pht_wr_idx <= '0;
         pht_wr_ctr <= '0;
         flush      <= 1'b0;
         res_err    <= 1'b0;
      end else begin
         pht_wr_en  <= pop;
         if (pop) begin
            pht_wr_idx <= head_idx;
            pht_wr_ctr <= new_ctr;
         end
         flush      <= mispredict;
         res_err    <= res_valid && (count == '0);
      end
   end

   // Saturating mispredict counter
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_count <= '0;
      end else if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
         mispredict_count <= mispredict_count + 32'd1;
      end
   end

`ifdef GPREDICT_CTRL_STATS_EN
   // Saturating retired-branch counter
   always_ff @(posedge clk) begin
      if (reset) begin
         resolved_count <= '0;
      end else if (pop && (resolved_count != 32'hFFFF_FFFF)) begin
         resolved_count <= resolved_count + 32'd1;
      end
   end
`else
   assign resolved_count = '0;
`endif

endmodule

// File: tb/tb_gpredict_ctrl.sv
// Self-checking bench for gpredict_ctrl (PC_W=8, GHR_W=8, DEPTH=4).
// Expected PHT writes are pushed to a scoreboard when a resolution is driven
// and popped when the DUT raises pht_wr_en.
module tb_gpredict_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        pred_valid;
   logic        pred_ready;
   logic [7:0]  pred_pc;
   logic        pred_taken;
   logic [7:0]  pht_rd_idx;
   logic [1:0]  pht_rd_ctr;
   logic        res_valid;
   logic        res_taken;
   logic        pht_wr_en;
   logic [7:0]  pht_wr_idx;
   logic [1:0]  pht_wr_ctr;
   logic        flush;
   logic        res_err;
   logic [7:0]  ghr;
   logic [2:0]  inflight;
   logic [31:0] mispredict_count;
   logic [31:0] resolved_count;

   gpredict_ctrl #(.PC_W(8), .GHR_W(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
      .pred_taken(pred_taken), .pht_rd_idx(pht_rd_idx), .pht_rd_ctr(pht_rd_ctr),
      .res_valid(res_valid), .res_taken(res_taken),
      .pht_wr_en(pht_wr_en), .pht_wr_idx(pht_wr_idx), .pht_wr_ctr(pht_wr_ctr),
      .flush(flush), .res_err(res_err), .ghr(ghr), .inflight(inflight),
      .mispredict_count(mispredict_count), .resolved_count(resolved_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] idx;
      logic [1:0] ctr;
      logic       pred;
      logic [7:0] g;
   } ent_t;

   typedef struct {
      logic [7:0] idx;
      logic [1:0] ctr;
   } wr_t;

   ent_t        m_q[$];
   wr_t         sb[$];
   logic [7:0]  m_ghr;
   logic [31:0] m_misp;
   logic [31:0] m_res;
   logic        exp_flush;
   logic        exp_err;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      pred_valid = 1'b0; pred_pc = '0; pht_rd_ctr = '0;
      res_valid  = 1'b0; res_taken = 1'b0;
   endtask

   task automatic check_regs();
      wr_t w;
      if (pht_wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wr_unexpected", 32'(pht_wr_en), 32'd0);
         end else begin
            w = sb.pop_front();
            chk("wr_idx", 32'(pht_wr_idx), 32'(w.idx));
            chk("wr_ctr", 32'(pht_wr_ctr), 32'(w.ctr));
         end
      end
      chk("wr_missing", 32'(sb.size()), 32'd0);
      sb.delete();
      chk("flush", 32'(flush), 32'(exp_flush));
      chk("res_err", 32'(res_err), 32'(exp_err));
      chk("ghr", 32'(ghr), 32'(m_ghr));
      chk("inflight", 32'(inflight), 32'(m_q.size()));
      chk("misp_count", 32'(mispredict_count), m_misp);
`ifdef GPREDICT_CTRL_STATS_EN
      chk("res_count", resolved_count, m_res);
`else
      chk("res_count", resolved_count, 32'd0);
`endif
   endtask

   // Reset held for two cycles with a resolution pending, which must not write
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      res_valid = 1'b1;
      pred_valid = 1'b1;
      @(posedge clk); #1;
      m_q.delete(); sb.delete();
      m_ghr = '0; m_misp = '0; m_res = '0; exp_flush = 1'b0; exp_err = 1'b0;
      check_regs();
      chk("rst_wr_en", 32'(pht_wr_en), 32'd0);
      @(posedge clk); #1;
      chk("rst_ready", 32'(pred_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic step(input logic pv, input logic [7:0] pc, input logic [1:0] c,
                       input logic rv, input logic rt);
      logic [7:0] idx;
      logic       acc;
      logic       misp;
      logic [1:0] nc;
      ent_t       h;
      ent_t       e;
      wr_t        w;
      @(negedge clk);
      pred_valid = pv; pred_pc = pc; pht_rd_ctr = c;
      res_valid  = rv; res_taken = rt;
      #1;
      idx = pc ^ m_ghr;
      chk("rd_idx", 32'(pht_rd_idx), 32'(idx));
      chk("pred_taken", 32'(pred_taken), 32'(c[1]));
      chk("pred_ready", 32'(pred_ready), 32'(m_q.size() != 4));
      acc  = pv && (m_q.size() != 4);
      misp = 1'b0;
      exp_flush = 1'b0;
      exp_err   = 1'b0;
      if (rv) begin
         if (m_q.size() == 0) begin
            exp_err = 1'b1;
         end else begin
            h = m_q.pop_front();
            if (rt) nc = (h.ctr == 2'd3) ? 2'd3 : h.ctr + 2'd1;
            else    nc = (h.ctr == 2'd0) ? 2'd0 : h.ctr - 2'd1;
            w.idx = h.idx; w.ctr = nc;
            sb.push_back(w);
            m_res++;
            misp = (rt != h.pred);
         end
      end
      if (misp) begin
         m_q.delete();
         m_ghr = {h.g[6:0], rt};
         m_misp++;
         exp_flush = 1'b1;
      end else if (acc) begin
         e.idx = idx; e.ctr = c; e.pred = c[1]; e.g = m_ghr;
         m_q.push_back(e);
         m_ghr = {m_ghr[6:0], c[1]};
      end
      @(posedge clk); #1;
      check_regs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      idle_inputs();
      m_ghr = '0; m_misp = '0; m_res = '0; exp_flush = 1'b0; exp_err = 1'b0;
      do_reset();

      // Single accept, then fill to DEPTH
      step(1'b1, 8'h05, 2'd2, 1'b0, 1'b0);
      chk("ghr_after_first", 32'(ghr), 32'h01);
      step(1'b1, 8'h10, 2'd3, 1'b0, 1'b0);
      step(1'b1, 8'h22, 2'd0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 2'd1, 1'b0, 1'b0);
      // Full: request ignored
      step(1'b1, 8'h44, 2'd3, 1'b0, 1'b0);
      chk("full_inflight", 32'(inflight), 32'd4);
      // Correct resolve of head (ctr 2, taken) while full: accept still refused
      step(1'b1, 8'h55, 2'd2, 1'b1, 1'b1);
      chk("correct_wr_ctr", 32'(pht_wr_ctr), 32'd3);
      chk("correct_wr_idx", 32'(pht_wr_idx), 32'h05);
      // Correct resolve with same-cycle accept: net occupancy
      step(1'b1, 8'h66, 2'd2, 1'b1, 1'b1);
      // Reset with entries in flight
      do_reset();

      // Mispredict with a same-cycle accept that must be dropped
      step(1'b1, 8'h05, 2'd2, 1'b0, 1'b0);
      step(1'b1, 8'h10, 2'd3, 1'b0, 1'b0);
      step(1'b1, 8'h77, 2'd3, 1'b1, 1'b0);
      chk("misp_flush", 32'(flush), 32'd1);
      chk("misp_wr_ctr", 32'(pht_wr_ctr), 32'd1);
      chk("misp_ghr", 32'(ghr), 32'h00);
      // flush is a single-cycle pulse
      step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
      // Resolution with empty queue
      step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
      chk("empty_res_err", 32'(res_err), 32'd1);
      step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

      // Counter saturation at 0 (not-taken prediction confirmed)
      step(1'b1, 8'h09, 2'd0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 4) < 2), 1'($urandom_range(0, 1)));
      end
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
